// File: rtl/exec_pkg.sv
// Shared types for the RV32I execute/memory/write-back datapath: ALU opcodes,
// forward-select encodings and the three pipeline-register payloads.
package exec_pkg;

  localparam int unsigned XLEN_W   = 32;
  localparam int unsigned RA_W_W   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FWD_W    = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [RA_W_W-1:0] rs1;
    logic [RA_W_W-1:0] rs2;
    logic [RA_W_W-1:0] rd;
    alu_op_e           alu_sel;
    logic [XLEN_W-1:0] a;
    logic [XLEN_W-1:0] b;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [RA_W_W-1:0] rd;
    logic [XLEN_W-1:0] result;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [RA_W_W-1:0] rd;
    logic [XLEN_W-1:0] data;
  } mem_wb_t;

  // A stage can supply rs only if it really writes a non-zero rd equal to rs.
  function automatic logic fwd_hit(input logic              valid,
                                   input logic              reg_write,
                                   input logic [RA_W_W-1:0] rd,
                                   input logic [RA_W_W-1:0] rs);
    return valid && reg_write && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl.sv
// Combinational forward-select and stall generation for the execute pipeline.
module hazard_fwd_ctrl
  import exec_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [RA_W_W-1:0] id_rs1_i,
  input  logic [RA_W_W-1:0] id_rs2_i,
  input  logic              id_ex_valid_i,
  input  logic              id_ex_reg_write_i,
  input  logic              id_ex_mem_read_i,
  input  logic [RA_W_W-1:0] id_ex_rd_i,
  input  logic [RA_W_W-1:0] id_ex_rs1_i,
  input  logic [RA_W_W-1:0] id_ex_rs2_i,
  input  logic              ex_mem_valid_i,
  input  logic              ex_mem_reg_write_i,
  input  logic [RA_W_W-1:0] ex_mem_rd_i,
  input  logic              mem_wb_valid_i,
  input  logic              mem_wb_reg_write_i,
  input  logic [RA_W_W-1:0] mem_wb_rd_i,
  output logic [FWD_W-1:0]  fwd_a_c_o,
  output logic [FWD_W-1:0]  fwd_b_c_o,
  output logic              stall_c_o
);

  logic load_use;
  logic raw_near;

  always_comb begin
    fwd_a_c_o = FWD_NONE;
    fwd_b_c_o = FWD_NONE;
    load_use  = 1'b0;
    raw_near  = 1'b0;
    stall_c_o = 1'b0;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    if (FWD_EN) begin
      if (fwd_hit(ex_mem_valid_i, ex_mem_reg_write_i, ex_mem_rd_i, id_ex_rs1_i)) begin
        fwd_a_c_o = FWD_MEM;
      end else if (fwd_hit(mem_wb_valid_i, mem_wb_reg_write_i, mem_wb_rd_i, id_ex_rs1_i)) begin
        fwd_a_c_o = FWD_WB;
      end
      if (fwd_hit(ex_mem_valid_i, ex_mem_reg_write_i, ex_mem_rd_i, id_ex_rs2_i)) begin
        fwd_b_c_o = FWD_MEM;
      end else if (fwd_hit(mem_wb_valid_i, mem_wb_reg_write_i, mem_wb_rd_i, id_ex_rs2_i)) begin
        fwd_b_c_o = FWD_WB;
      end
    end

    load_use = id_ex_valid_i && id_ex_mem_read_i && (id_ex_rd_i != '0) &&
               ((id_ex_rd_i == id_rs1_i) || (id_ex_rd_i == id_rs2_i));

    // Without forwarding, wait until the producer reaches MEM/WB where the capture bypass covers it.
    raw_near = fwd_hit(id_ex_valid_i, id_ex_reg_write_i, id_ex_rd_i, id_rs1_i)   ||
               fwd_hit(id_ex_valid_i, id_ex_reg_write_i, id_ex_rd_i, id_rs2_i)   ||
               fwd_hit(ex_mem_valid_i, ex_mem_reg_write_i, ex_mem_rd_i, id_rs1_i) ||
               fwd_hit(ex_mem_valid_i, ex_mem_reg_write_i, ex_mem_rd_i, id_rs2_i);

    stall_c_o = id_valid_i && !flush_i && (FWD_EN ? load_use : raw_near);
  end

endmodule

// File: rtl/exec_pipe_fwd.sv
// ID/EX -> EX/MEM -> MEM/WB datapath with ALU, operand forwarding, load-use
// stall, write-back capture bypass and branch flush.
module exec_pipe_fwd
  import exec_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_W,
  parameter int unsigned RA_W   = RA_W_W,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_a,
  input  logic [XLEN-1:0] id_b,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            flush,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            ex_zero,
  output logic [XLEN-1:0] ex_result,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned SHAMT_W = $clog2(XLEN_W);

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic [FWD_W-1:0]   fwd_a;
  logic [FWD_W-1:0]   fwd_b;
  logic               stall_c;
  logic [RA_W_W-1:0]  rs1_w;
  logic [RA_W_W-1:0]  rs2_w;
  logic               byp_a;
  logic               byp_b;
  logic [XLEN_W-1:0]  op_a;
  logic [XLEN_W-1:0]  op_b;
  logic [XLEN_W-1:0]  alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign rs1_w = RA_W_W'(id_rs1);
  assign rs2_w = RA_W_W'(id_rs2);

  hazard_fwd_ctrl #(
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .flush_i            (flush),
    .id_valid_i         (id_valid),
    .id_rs1_i           (rs1_w),
    .id_rs2_i           (rs2_w),
    .id_ex_valid_i      (id_ex_q.valid),
    .id_ex_reg_write_i  (id_ex_q.reg_write),
    .id_ex_mem_read_i   (id_ex_q.mem_read),
    .id_ex_rd_i         (id_ex_q.rd),
    .id_ex_rs1_i        (id_ex_q.rs1),
    .id_ex_rs2_i        (id_ex_q.rs2),
    .ex_mem_valid_i     (ex_mem_q.valid),
    .ex_mem_reg_write_i (ex_mem_q.reg_write),
    .ex_mem_rd_i        (ex_mem_q.rd),
    .mem_wb_valid_i     (mem_wb_q.valid),
    .mem_wb_reg_write_i (mem_wb_q.reg_write),
    .mem_wb_rd_i        (mem_wb_q.rd),
    .fwd_a_c_o          (fwd_a),
    .fwd_b_c_o          (fwd_b),
    .stall_c_o          (stall_c)
  );

  // The register bank writes at the end of WB, so a same-cycle read is stale.
  assign byp_a = fwd_hit(mem_wb_q.valid, mem_wb_q.reg_write, mem_wb_q.rd, rs1_w);
  assign byp_b = fwd_hit(mem_wb_q.valid, mem_wb_q.reg_write, mem_wb_q.rd, rs2_w);

  // ID/EX capture; stall or flush inserts a bubble.
  always_comb begin
    id_ex_d = '0;
    if (id_valid && !stall_c && !flush) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.reg_write = id_reg_write;
      id_ex_d.mem_read  = id_mem_read;
      id_ex_d.rs1       = rs1_w;
      id_ex_d.rs2       = rs2_w;
      id_ex_d.rd        = RA_W_W'(id_rd);
      id_ex_d.alu_sel   = alu_op_e'(id_alu_sel);
      id_ex_d.a         = byp_a ? mem_wb_q.data : XLEN_W'(id_a);
      id_ex_d.b         = byp_b ? mem_wb_q.data : XLEN_W'(id_b);
    end
  end

  always_comb begin
    case (fwd_a)
      FWD_MEM: op_a = ex_mem_q.result;
      FWD_WB:  op_a = mem_wb_q.data;
      default: op_a = id_ex_q.a;
    endcase
    case (fwd_b)
      FWD_MEM: op_b = ex_mem_q.result;
      FWD_WB:  op_b = mem_wb_q.data;
      default: op_b = id_ex_q.b;
    endcase
  end

  always_comb begin
    alu_res = '0;
    shamt   = op_b[SHAMT_W-1:0];
    case (id_ex_q.alu_sel)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = XLEN_W'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN_W'(op_a < op_b);
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = XLEN_W'($signed(op_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.valid     = id_ex_q.valid;
    ex_mem_d.reg_write = id_ex_q.valid && id_ex_q.reg_write;
    ex_mem_d.mem_read  = id_ex_q.valid && id_ex_q.mem_read;
    ex_mem_d.rd        = id_ex_q.rd;
    ex_mem_d.result    = alu_res;
  end

  // Memory stage: loads take the returned data, everything else the ALU result.
  always_comb begin
    mem_wb_d           = '0;
    mem_wb_d.valid     = ex_mem_q.valid;
    mem_wb_d.reg_write = ex_mem_q.valid && ex_mem_q.reg_write;
    mem_wb_d.rd        = ex_mem_q.rd;
    mem_wb_d.data      = ex_mem_q.mem_read ? XLEN_W'(mem_rdata) : ex_mem_q.result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign stall        = stall_c;
  assign ex_zero      = id_ex_q.valid && (alu_res == '0);
  assign ex_result    = XLEN'(ex_mem_q.result);
  assign wb_valid     = mem_wb_q.valid;
  assign wb_reg_write = mem_wb_q.reg_write;
  assign wb_rd        = RA_W'(mem_wb_q.rd);
  assign wb_data      = XLEN'(mem_wb_q.data);

endmodule

// File: tb/tb_exec_pipe_fwd.sv
// Bench for exec_pipe_fwd: an in-order architectural register model plus a
// delayed register bank, driven by directed sequences and random programs.
module tb_exec_pipe_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_a, id_b;
  logic [3:0]  id_alu_sel;
  logic        id_reg_write, id_mem_read, flush;
  logic [31:0] mem_rdata;
  logic        stall, ex_zero;
  logic [31:0] ex_result;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  exec_pipe_fwd dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_a         (id_a),
    .id_b         (id_b),
    .id_alu_sel   (id_alu_sel),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .ex_zero      (ex_zero),
    .ex_result    (ex_result),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  op;
    bit        rw, ld;
    bit [31:0] ldata;
  } ins_t;

  typedef struct {
    bit        valid, rw, ld;
    bit [4:0]  rd;
    bit [31:0] alu, wbd;
  } slot_t;

  // arch: program-order state; bank: what the real register file holds (written at end of WB).
  bit [31:0] arch [32];
  bit [31:0] bank [32];
  bit [31:0] dut_wb [32];
  slot_t     s0, s1, s2;
  int        checks = 0;
  int        errors = 0;
  int        dut_stalls = 0;
  localparam bit [31:0] SENT = 32'hDEAD_BEEF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] alu(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.rw = 0; s.ld = 0; s.rd = 0; s.alu = 0; s.wbd = 0;
    return s;
  endfunction

  function automatic ins_t mk(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                              input bit [3:0] op);
    ins_t r;
    r.v = 1; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.op = op; r.rw = 1; r.ld = 0; r.ldata = 0;
    return r;
  endfunction

  function automatic ins_t mkld(input bit [4:0] rd, input bit [4:0] rs1, input bit [31:0] d);
    ins_t r;
    r = mk(rd, rs1, 5'd0, 4'd0);
    r.ld = 1; r.ldata = d;
    return r;
  endfunction

  function automatic ins_t bubble();
    ins_t r;
    r = mk(5'd0, 5'd0, 5'd0, 4'd0);
    r.v = 0; r.rw = 0;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r;
    r.v     = ($urandom_range(0, 9) != 0);
    r.rs1   = 5'($urandom_range(0, 7));
    r.rs2   = 5'($urandom_range(0, 7));
    r.rd    = 5'($urandom_range(0, 7));
    r.ld    = ($urandom_range(0, 4) == 0);
    r.rw    = r.ld ? 1'b1 : ($urandom_range(0, 5) != 0);
    r.op    = r.ld ? 4'd0 : 4'($urandom_range(0, 15));
    r.ldata = $urandom();
    return r;
  endfunction

  // One clock: drive ID, check outputs at negedge, advance the model at posedge.
  task automatic step(input ins_t in, input bit fl, output bit st_exp, output bit st_obs);
    slot_t     ns;
    bit [31:0] a, b, r;
    id_valid     = in.v;
    id_rs1       = in.rs1;
    id_rs2       = in.rs2;
    id_rd        = in.rd;
    id_alu_sel   = in.op;
    id_reg_write = in.rw;
    id_mem_read  = in.ld;
    id_a         = bank[in.rs1];
    id_b         = bank[in.rs2];
    flush        = fl;
    mem_rdata    = (s1.valid && s1.ld) ? s1.wbd : $urandom();
    @(negedge clk);
    st_exp = in.v && !fl && s0.valid && s0.ld && (s0.rd != 0) &&
             ((s0.rd == in.rs1) || (s0.rd == in.rs2));
    st_obs = stall;
    if (stall) dut_stalls++;
    chk("stall", 32'(stall), 32'(st_exp));
    chk("wb_valid", 32'(wb_valid), 32'(s2.valid));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(s2.valid && s2.rw));
    if (s2.valid) begin
      chk("wb_rd", 32'(wb_rd), 32'(s2.rd));
      chk("wb_data", wb_data, s2.wbd);
    end
    if (s1.valid) chk("ex_result", ex_result, s1.alu);
    chk("ex_zero", 32'(ex_zero), 32'(s0.valid && (s0.alu == 0)));
    if (wb_valid && wb_reg_write) dut_wb[wb_rd] = wb_data;
    ns = empty_slot();
    if (in.v && !fl && !st_exp) begin
      a = arch[in.rs1];
      b = arch[in.rs2];
      r = alu(in.op, a, b);
      ns.valid = 1; ns.rw = in.rw; ns.ld = in.ld; ns.rd = in.rd;
      ns.alu = r;
      ns.wbd = in.ld ? in.ldata : r;
      if (in.rw && in.rd != 0) arch[in.rd] = ns.wbd;
    end
    @(posedge clk);
    #1;
    if (s2.valid && s2.rw && s2.rd != 0) bank[s2.rd] = s2.wbd;
    s2 = s1;
    s1 = s0;
    s0 = ns;
  endtask

  task automatic issue(input ins_t in);
    bit se, so;
    int n;
    step(in, 1'b0, se, so);
    n = 0;
    while (se && n < 3) begin
      step(in, 1'b0, se, so);
      n++;
    end
    if (se) begin
      checks++;
      errors++;
      $display("FAIL stall_bound instruction still stalled after %0d retries", n);
    end
  endtask

  task automatic idle(input int n);
    bit se, so;
    for (int i = 0; i < n; i++) step(bubble(), 1'b0, se, so);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_ex_zero"}, 32'(ex_zero), 32'd0);
    chk({tag, "_ex_result"}, ex_result, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  task automatic set_reg(input int r, input bit [31:0] v);
    bank[r] = v;
    arch[r] = v;
  endtask

  initial begin
    bit se, so;
    int st0;
    s0 = empty_slot(); s1 = empty_slot(); s2 = empty_slot();
    for (int i = 0; i < 32; i++) begin
      bank[i]   = (i == 0) ? 32'd0 : $urandom();
      arch[i]   = bank[i];
      dut_wb[i] = SENT;
    end
    reset = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_a = 0; id_b = 0;
    id_alu_sel = 0; id_reg_write = 0; id_mem_read = 0; flush = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    set_reg(10, 32'd5);   set_reg(11, 32'd7);  set_reg(12, 32'h10); set_reg(13, 32'd1);
    set_reg(14, 32'd9);   set_reg(16, 32'hAA); set_reg(6, 32'd0);
    set_reg(18, 32'h8000_0000); set_reg(19, 32'h24);

    // Back-to-back dependency through EX/MEM on both operands.
    st0 = dut_stalls;
    issue(mk(5'd1, 5'd10, 5'd11, 4'd0));
    issue(mk(5'd2, 5'd1, 5'd1, 4'd0));
    idle(3);
    chk("fwd_mem_x1", dut_wb[1], 32'd12);
    chk("fwd_mem_x2", dut_wb[2], 32'd24);
    chk("fwd_mem_nostall", 32'(dut_stalls - st0), 32'd0);
    chk("model_x2", arch[2], 32'd24);

    // Dependency two apart goes through MEM/WB.
    issue(mk(5'd3, 5'd12, 5'd0, 4'd0));
    issue(mk(5'd7, 5'd10, 5'd11, 4'd0));
    issue(mk(5'd8, 5'd3, 5'd13, 4'd0));
    idle(3);
    chk("fwd_wb_x8", dut_wb[8], 32'h11);

    // Load-use: one stall cycle, then data from MEM/WB.
    st0 = dut_stalls;
    issue(mkld(5'd4, 5'd0, 32'h1234_5678));
    issue(mk(5'd5, 5'd4, 5'd13, 4'd0));
    idle(3);
    chk("load_use_stalls", 32'(dut_stalls - st0), 32'd1);
    chk("load_use_x4", dut_wb[4], 32'h1234_5678);
    chk("load_use_x5", dut_wb[5], 32'h1234_5679);

    // x0 is never forwarded.
    issue(mk(5'd0, 5'd14, 5'd0, 4'd0));
    issue(mk(5'd9, 5'd0, 5'd13, 4'd0));
    idle(3);
    chk("x0_nofwd_x9", dut_wb[9], 32'd1);

    // Flush wins over a load-use stall; the load still retires.
    dut_wb[15] = SENT;
    issue(mkld(5'd4, 5'd0, 32'hCAFE_F00D));
    step(mk(5'd15, 5'd4, 5'd13, 4'd0), 1'b1, se, so);
    chk("flush_stall_obs", 32'(so), 32'd0);
    idle(3);
    chk("flush_killed_x15", dut_wb[15], SENT);
    chk("flush_older_x4", dut_wb[4], 32'hCAFE_F00D);

    // Capture bypass: bank still reads 0 for x6 while it is in WB.
    issue(mk(5'd6, 5'd16, 5'd0, 4'd0));
    idle(2);
    chk("bypass_stale_bank", bank[6], 32'd0);
    issue(mk(5'd17, 5'd6, 5'd0, 4'd0));
    idle(3);
    chk("bypass_x17", dut_wb[17], 32'hAA);

    // ALU corner cases: SRA uses low 5 bits of B, SUB wraps, undefined op gives 0.
    issue(mk(5'd23, 5'd18, 5'd19, 4'd9));
    issue(mk(5'd24, 5'd0, 5'd13, 4'd1));
    issue(mk(5'd25, 5'd10, 5'd11, 4'd12));
    idle(3);
    chk("sra_x23", dut_wb[23], 32'hF800_0000);
    chk("sub_wrap_x24", dut_wb[24], 32'hFFFF_FFFF);
    chk("undef_op_x25", dut_wb[25], 32'd0);

    // Asynchronous reset with three instructions in flight.
    dut_wb[20] = SENT; dut_wb[21] = SENT; dut_wb[22] = SENT;
    issue(mk(5'd20, 5'd10, 5'd11, 4'd0));
    issue(mk(5'd21, 5'd10, 5'd11, 4'd3));
    issue(mk(5'd22, 5'd10, 5'd11, 4'd4));
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    id_valid = 0;
    flush = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    s0 = empty_slot(); s1 = empty_slot(); s2 = empty_slot();
    for (int i = 0; i < 32; i++) arch[i] = bank[i];
    idle(4);
    chk("midrst_x20", dut_wb[20], SENT);
    chk("midrst_x21", dut_wb[21], SENT);
    chk("midrst_x22", dut_wb[22], SENT);

    // Random programs on a small register window for dense hazards.
    for (int i = 0; i < 2500; i++) begin
      ins_t r;
      r = rnd_ins();
      if ($urandom_range(0, 11) == 0) step(r, 1'b1, se, so);
      else issue(r);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
